// File: rtl/lsu_vq.sv
`default_nettype none
// ============================================================================
// Module   : lsu_vq
// Purpose  : Dirty-victim FIFO between D$ eviction and memory write-back. It
//            coalesces re-evictions and serves load lookups from queued lines.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_vq #(
  parameter int OPTN_DATA_WIDTH   = 32,
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_DC_LINE_SIZE = 32,
  parameter int OPTN_VQ_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_victim_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]       i_victim_addr,
  input  logic [OPTN_DC_LINE_SIZE*8-1:0]   i_victim_data,
  output logic                             o_full,
  output logic                             o_empty,
  input  logic                             i_lookup_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]       i_lookup_addr,
  output logic                             o_lookup_hit,
  output logic [OPTN_DATA_WIDTH-1:0]       o_lookup_data,
  output logic                             o_wb_valid,
  output logic [OPTN_ADDR_WIDTH-1:0]       o_wb_addr,
  output logic [OPTN_DC_LINE_SIZE*8-1:0]   o_wb_data,
  input  logic                             i_wb_ready
);

  localparam int DC_LINE_WIDTH = OPTN_DC_LINE_SIZE * 8;
  localparam int OFS           = $clog2(OPTN_DC_LINE_SIZE);
  localparam int WOFS          = $clog2(OPTN_DATA_WIDTH / 8);
  localparam int WIDX_W        = OFS - WOFS;
  localparam int WORDS         = DC_LINE_WIDTH / OPTN_DATA_WIDTH;
  localparam int PTR_W         = $clog2(OPTN_VQ_DEPTH);
  localparam int CNT_W         = PTR_W + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                     r_state;
  logic [OPTN_VQ_DEPTH-1:0]   r_valid;
  logic [OPTN_ADDR_WIDTH-1:0] r_addr [OPTN_VQ_DEPTH];
  logic [DC_LINE_WIDTH-1:0]   r_data [OPTN_VQ_DEPTH];
  logic [PTR_W-1:0]           r_head;
  logic [PTR_W-1:0]           r_tail;
  logic [CNT_W-1:0]           r_count;

  logic [OPTN_ADDR_WIDTH-1:0] w_victim_line;
  logic                       w_coal_hit;
  logic [PTR_W-1:0]           w_coal_idx;
  logic                       w_coal_wr;
  logic                       w_alloc;
  logic                       w_xfer;
  logic [CNT_W-1:0]           w_count_nxt;
  logic                       w_lk_hit;
  logic [PTR_W-1:0]           w_lk_idx;
  logic [WIDX_W-1:0]          w_word;
  logic                       w_unused_ok;

  assign w_victim_line = {i_victim_addr[OPTN_ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
  assign w_word        = i_lookup_addr[OFS-1:WOFS];
  assign w_unused_ok   = ^{i_victim_addr, i_lookup_addr};

  assign o_full     = (r_count == CNT_W'(OPTN_VQ_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_wb_valid = (r_state == S_DRAIN);
  assign o_wb_addr  = o_wb_valid ? r_addr[r_head] : '0;
  assign o_wb_data  = o_wb_valid ? r_data[r_head] : '0;

  // The presented head is never a coalesce target, so its data stays stable.
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    for (int i = 0; i < OPTN_VQ_DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == w_victim_line) &&
          !((r_state == S_DRAIN) && (PTR_W'(i) == r_head))) begin
        w_coal_hit = 1'b1;
        w_coal_idx = PTR_W'(i);
      end
    end
  end

  assign w_coal_wr = i_victim_en && w_coal_hit;
  assign w_alloc   = i_victim_en && !w_coal_hit && !o_full;
  assign w_xfer    = o_wb_valid && i_wb_ready;

  always_comb begin
    case ({w_alloc, w_xfer})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Walk from head towards tail so the youngest matching line wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
    idx      = '0;
    for (int k = 0; k < OPTN_VQ_DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if (r_valid[idx] &&
          (r_addr[idx][OPTN_ADDR_WIDTH-1:OFS] == i_lookup_addr[OPTN_ADDR_WIDTH-1:OFS])) begin
        w_lk_hit = 1'b1;
        w_lk_idx = idx;
      end
    end
  end

  always_comb begin
    o_lookup_hit  = i_lookup_en && w_lk_hit;
    o_lookup_data = '0;
    if (o_lookup_hit) begin
      for (int w = 0; w < WORDS; w++) begin
        if (WIDX_W'(w) == w_word)
          o_lookup_data = r_data[w_lk_idx][w*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < OPTN_VQ_DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_coal_wr)
        r_data[w_coal_idx] <= i_victim_data;
      // Allocation never lands on the head: tail==head only when empty or full.
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= w_victim_line;
        r_data[r_tail]  <= i_victim_data;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_xfer) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      case (r_state)
        S_IDLE:  if (w_alloc) r_state <= S_DRAIN;
        S_DRAIN: if (w_xfer && (r_count == CNT_W'(1)) && !w_alloc) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu_vq.md
# lsu_vq

Parametrised dirty-victim queue for the LSU. It sits between the EX-stage victim outputs and the memory write-back path. Each dirty line evicted from the D$ is buffered here in a FIFO of `OPTN_VQ_DEPTH` entries and drained in order over a valid/ready port. Load lookups that miss the D$ can find a line still held in the queue, and a re-eviction of a line already queued overwrites that entry in place instead of taking a new one.

## Interface
- `OPTN_DATA_WIDTH`, 32: load word width; multiple of 8.
- `OPTN_ADDR_WIDTH`, 32: address width.
- `OPTN_DC_LINE_SIZE`, 32: line size in bytes; power of two.
- `OPTN_VQ_DEPTH`, 4: number of entries; power of two, ≥2.
- Derived: `DC_LINE_WIDTH` = `OPTN_DC_LINE_SIZE`*8; `OFS` = log2(`OPTN_DC_LINE_SIZE`); `WOFS` = log2(`OPTN_DATA_WIDTH`/8).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_victim_en`  in  1  enqueue a dirty victim line this cycle.
- `i_victim_addr`  in  `OPTN_ADDR_WIDTH`  victim address; bits [OFS-1:0] are forced to 0 on store.
- `i_victim_data`  in  `DC_LINE_WIDTH`  victim line data.
- `o_full`  out  1  count == `OPTN_VQ_DEPTH`.
- `o_empty`  out  1  count == 0.
- `i_lookup_en`  in  1  load lookup request.
- `i_lookup_addr`  in  `OPTN_ADDR_WIDTH`  lookup byte address.
- `o_lookup_hit`  out  1  a valid entry matches the line.
- `o_lookup_data`  out  `OPTN_DATA_WIDTH`  selected word from the matching line.
- `o_wb_valid`  out  1  the head entry is presented for write-back.
- `o_wb_addr`  out  `OPTN_ADDR_WIDTH`  head line address (aligned).
- `o_wb_data`  out  `DC_LINE_WIDTH`  head line data.
- `i_wb_ready`  in  1  the write-back consumer accepts the head entry.

## Operation
- Storage: per entry a valid bit, an aligned address and a line.
  - Head and tail pointers are log2(`OPTN_VQ_DEPTH`) bits wide and wrap modulo the depth.
  - Count is log2(`OPTN_VQ_DEPTH`)+1 bits wide.
- Drain FSM has two states.
  - IDLE (count==0): `o_wb_valid`=0.
  - DRAIN (count>0): `o_wb_valid`=1; `o_wb_addr`/`o_wb_data` come from the head entry.
  - DRAIN→IDLE when a handshake completes with count==1 and there is no enqueue in the same cycle.
  - IDLE→DRAIN on any enqueue.
- Handshake: a transfer completes on an edge where `o_wb_valid` & `i_wb_ready`. On that edge the head entry is invalidated and the head pointer advances.
- Stability: while `o_wb_valid`=1 and the transfer has not completed, `o_wb_addr` and `o_wb_data` do not change.
- Enqueue (`i_victim_en`=1): compare the aligned address against all valid entries except the head while the FSM is in DRAIN.
  - Coalesce hit (at most one match by construction): overwrite that entry's data. Count and tail are unchanged. This is accepted even when `o_full`=1.
  - Otherwise: write the entry at tail, advance tail, count+1.
  - Enqueue with `o_full`=1 and no coalesce hit is a protocol violation. The request is dropped and state is unchanged.
  - Coalescing never targets the head while it is presented. A match on the head allocates a new entry.
- Lookup: purely combinational from registered state; `i_lookup_en`=0 forces `o_lookup_hit`=0.
  - Line match is on address bits [`OPTN_ADDR_WIDTH`-1:OFS].
  - If several entries match, the youngest (closest to tail) wins.
  - `o_lookup_data` is the word at index addr[OFS-1:WOFS] of the winning line; it is 0 on a miss.
- Simultaneous enqueue (allocating) and transfer: count is unchanged and both pointers advance.
- Simultaneous coalesce and transfer: count-1. The coalesce target is never the head being transferred.

## Timing
- Reset values: all valid bits 0, pointers 0, count 0, FSM IDLE. Outputs: `o_full`=0, `o_empty`=1, `o_wb_valid`=0, `o_lookup_hit`=0, `o_lookup_data`=0, `o_wb_addr`=0, `o_wb_data`=0.
- Reset mid-transfer discards all entries immediately; no handshake completes.
- An enqueued entry is visible to lookup, coalescing and `o_wb_valid` one cycle after the enqueue edge. There is no same-cycle bypass.
- Earliest write-back is one cycle after enqueue. Back-to-back transfers run with no bubble while `i_wb_ready`=1.
- `o_full`/`o_empty` reflect the count register. A drain in the same cycle does not free a slot for that cycle's enqueue.

## Test plan
- Reset, depth 4: assert `rst` mid-stream with 3 entries → `o_empty`=1, `o_full`=0, `o_wb_valid`=0 in the same cycle; a lookup of any address misses.
- Basic flow:
  - Stimulus: enqueue 0x1000 with data word k = k+0xA0 (k=0..7), `i_wb_ready`=0.
  - Next cycle: `o_wb_valid`=1 and `o_wb_addr`=0x1000.
  - Lookup 0x1008 → hit, data 0xA2, held stable for 3 cycles.
  - Then ready=1 for 1 cycle → `o_empty`=1 on the next cycle.
- Full and coalesce:
  - Stimulus: ready=0; enqueue 0x1000, 0x2000, 0x3000, 0x4000 → `o_full`=1.
  - Enqueue 0x301F with new data → accepted, stored at 0x3000, count stays 4.
  - Drain order is 0x1000, 0x2000, 0x3000 (new data), 0x4000.
- Head protection: with head 0x1000 presented, ready=0, enqueue 0x1000 with data B → count=2.
  - `o_wb_data` remains the old line.
  - Lookup 0x1000 returns B's word 0.
  - Both entries drain, in order.
- Wrap and concurrency:
  - Keep 2 entries resident; each cycle for 7 cycles, enqueue address 0x100*i and assert ready.
  - Count stays 2 throughout.
  - The write-back address sequence exactly equals the enqueue order across pointer wrap.
- Full-drop: at `o_full`=1, enqueue a non-matching 0x9000 → dropped; no entry at 0x9000 ever appears on write-back.
